// File: rtl/hellorld_rx.sv
// -----------------------------------------------------------------------------
// hellorld_rx
//
// Serial receiver and message checker for the "Hellorld!\r\n" UART stream.
// The line is oversampled with a counter driven by the same 12-bit divisor as
// the transmitter (bit period P = baud_div + 1 clocks). Characters are 8N1,
// LSB-first. Each good character is compared against the fixed 11-character
// message; the checker reports lock status, completed lines and a saturating
// error count for loopback self-test.
//
// Ports
//   wb_clk_i    in   clock
//   rst_n       in   synchronous, active-low reset
//   rx_in       in   serial line, idle high
//   baud_div    in   [11:0] bit period minus one (3..4095)
//   clear       in   synchronous clear of line_count, err_count and lock
//   rx_data     out  [7:0] last good byte, held until the next one
//   rx_valid    out  one-cycle strobe, rx_data updated in the same cycle
//   frame_err   out  one-cycle strobe, stop bit sampled low
//   mismatch    out  one-cycle strobe, locked and byte != expected
//   locked      out  checker aligned to the message
//   line_count  out  [LINE_W-1:0] completed messages (wraps)
//   err_count   out  [ERR_W-1:0] frame_err + mismatch events (saturates)
//   dbg_state_o out  [2:0] receiver FSM state (rx_state_e encoding)
//   dbg_ptr_o   out  [3:0] message pointer of the checker
//
// Handshake: rx_valid and frame_err are single-cycle strobes with no ready;
// a consumer must sample on the cycle they are high. They are never high in
// the same cycle. mismatch only ever accompanies rx_valid.
// -----------------------------------------------------------------------------
module hellorld_rx #(
    parameter int LINE_W = 16,
    parameter int ERR_W  = 8
) (
    input  logic              wb_clk_i,
    input  logic              rst_n,
    input  logic              rx_in,
    input  logic [11:0]       baud_div,
    input  logic              clear,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              mismatch,
    output logic              locked,
    output logic [LINE_W-1:0] line_count,
    output logic [ERR_W-1:0]  err_count,
    output logic [2:0]        dbg_state_o,
    output logic [3:0]        dbg_ptr_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } rx_state_e;

    localparam logic [LINE_W-1:0] LINE_ONE = LINE_W'(1);
    localparam logic [ERR_W-1:0]  ERR_ONE  = ERR_W'(1);
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

    // ------------------------------------------------------------------
    // Input synchronizer and edge detection
    // ------------------------------------------------------------------
    logic       sync1_q;
    logic       sync_q;
    logic       prev_q;
    // Counts the cycles after reset until sync_q carries a genuine sample of
    // rx_in. Until then prev_q is held at 0 so the reset value (1) of the
    // synchronizer cannot masquerade as a line that was high and make a
    // line that is still low look like a fresh falling edge.
    logic [1:0] fill_q;
    logic [1:0] fill_d;
    logic       fill_done;

    assign fill_done = (fill_q == 2'd2);
    assign fill_d    = fill_done ? fill_q : fill_q + 2'd1;

    // ------------------------------------------------------------------
    // Receiver FSM state
    // ------------------------------------------------------------------
    rx_state_e   state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [11:0] half_div;
    logic        byte_done;   // stop bit sampled high this cycle
    logic        stop_bad;    // stop bit sampled low this cycle

    assign half_div = {1'b0, baud_div[11:1]};

    // ------------------------------------------------------------------
    // Checker and output registers
    // ------------------------------------------------------------------
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              mismatch_q, mismatch_d;
    logic              locked_q, locked_d;
    logic [3:0]        ptr_q, ptr_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              err_inc;
    logic [7:0]        exp_byte;

    // Fixed message "Hellorld!\r\n", indexed by the checker pointer.
    function automatic logic [7:0] msg_char(input logic [3:0] idx);
        logic [7:0] c;
        case (idx)
            4'd0:    c = 8'h48;
            4'd1:    c = 8'h65;
            4'd2:    c = 8'h6C;
            4'd3:    c = 8'h6C;
            4'd4:    c = 8'h6F;
            4'd5:    c = 8'h72;
            4'd6:    c = 8'h6C;
            4'd7:    c = 8'h64;
            4'd8:    c = 8'h21;
            4'd9:    c = 8'h0D;
            4'd10:   c = 8'h0A;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    assign exp_byte = msg_char(ptr_q);

    // ------------------------------------------------------------------
    // Receiver next-state logic
    // ------------------------------------------------------------------
    // Counters compare for equality. If baud_div is lowered mid-frame so that
    // cnt_q is already past it, the 12-bit counter wraps and meets the new
    // compare value later, so the FSM still completes and returns to IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!sync_q && prev_q) begin
                    cnt_d   = 12'd0;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == half_div) begin
                    if (sync_q) begin
                        // Line back high at mid start bit: a glitch, drop it.
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = 12'd0;
                        bit_d   = 3'd0;
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end

            S_DATA: begin
                if (cnt_q == baud_div) begin
                    shift_d = {sync_q, shift_q[7:1]};  // LSB arrives first
                    cnt_d   = 12'd0;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end

            S_STOP: begin
                if (cnt_q == baud_div) begin
                    cnt_d = 12'd0;
                    if (sync_q) begin
                        byte_done = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end

            S_WAIT_HIGH: begin
                // A low stop bit may be a break or a mis-aligned frame; do not
                // hunt for a start edge until the line has returned high.
                if (sync_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Message checker next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        mismatch_d  = 1'b0;
        locked_d    = locked_q;
        ptr_d       = ptr_q;
        line_d      = line_q;
        err_inc     = 1'b0;

        if (byte_done) begin
            rx_valid_d = 1'b1;
            rx_data_d  = shift_q;
            if (!locked_q) begin
                // Hunting: only the first message character starts alignment.
                if (shift_q == 8'h48) begin
                    locked_d = 1'b1;
                    ptr_d    = 4'd1;
                end
            end else if (shift_q == exp_byte) begin
                if (ptr_q == 4'd10) begin
                    ptr_d  = 4'd0;
                    line_d = line_q + LINE_ONE;
                end else begin
                    ptr_d = ptr_q + 4'd1;
                end
            end else begin
                mismatch_d = 1'b1;
                err_inc    = 1'b1;
                // An unexpected 'H' is most likely the start of a fresh
                // message, so realign to it straight away.
                if (shift_q == 8'h48) begin
                    locked_d = 1'b1;
                    ptr_d    = 4'd1;
                end else begin
                    locked_d = 1'b0;
                    ptr_d    = 4'd0;
                end
            end
        end

        if (stop_bad) begin
            frame_err_d = 1'b1;
            err_inc     = 1'b1;
        end

        err_d = (err_inc && (err_q != ERR_MAX)) ? err_q + ERR_ONE : err_q;

        // clear has priority over any same-cycle increment or relock.
        if (clear) begin
            line_d   = '0;
            err_d    = '0;
            locked_d = 1'b0;
            ptr_d    = 4'd0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync_q      <= 1'b1;
            prev_q      <= 1'b0;
            fill_q      <= 2'd0;
            state_q     <= S_IDLE;
            cnt_q       <= 12'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            mismatch_q  <= 1'b0;
            locked_q    <= 1'b0;
            ptr_q       <= 4'd0;
            line_q      <= '0;
            err_q       <= '0;
        end else begin
            sync1_q     <= rx_in;
            sync_q      <= sync1_q;
            prev_q      <= fill_done ? sync_q : 1'b0;
            fill_q      <= fill_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            mismatch_q  <= mismatch_d;
            locked_q    <= locked_d;
            ptr_q       <= ptr_d;
            line_q      <= line_d;
            err_q       <= err_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign mismatch    = mismatch_q;
    assign locked      = locked_q;
    assign line_count  = line_q;
    assign err_count   = err_q;
    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_hellorld_rx.sv
// -----------------------------------------------------------------------------
// tb_hellorld_rx
//
// Drives the receiver with a behavioural 8N1 UART and predicts every strobe
// with a message-level reference model. Expected strobes are queued when a
// character is issued; a monitor on the falling clock edge pops and compares
// each rx_valid / frame_err the DUT produces.
// -----------------------------------------------------------------------------
module tb_hellorld_rx;

    logic        wb_clk_i = 1'b0;
    logic        rst_n    = 1'b0;
    logic        rx_in    = 1'b1;
    logic [11:0] baud_div = 12'd15;
    logic        clear    = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        mismatch;
    logic        locked;
    logic [15:0] line_count;
    logic [7:0]  err_count;
    logic [2:0]  dbg_state_o;
    logic [3:0]  dbg_ptr_o;

    hellorld_rx #(.LINE_W(16), .ERR_W(8)) dut (
        .wb_clk_i    (wb_clk_i),
        .rst_n       (rst_n),
        .rx_in       (rx_in),
        .baud_div    (baud_div),
        .clear       (clear),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .mismatch    (mismatch),
        .locked      (locked),
        .line_count  (line_count),
        .err_count   (err_count),
        .dbg_state_o (dbg_state_o),
        .dbg_ptr_o   (dbg_ptr_o)
    );

    // ---------------- clock ----------------
    always #5 wb_clk_i = ~wb_clk_i;

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        is_fe;
        logic [7:0]  data;
        logic        mm;
        logic        lk;
        logic [15:0] lines;
        logic [7:0]  errs;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0] msg [11] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h72,
                             8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};

    // Reference model: message position, lock and counters.
    logic        m_locked = 1'b0;
    int          m_ptr    = 0;
    logic [15:0] m_lines  = 16'd0;
    logic [7:0]  m_errs   = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_ptr    = 0;
        m_lines  = 16'd0;
        m_errs   = 8'd0;
    endtask

    task automatic model_err();
        if (m_errs != 8'hFF) m_errs = m_errs + 8'd1;
    endtask

    // Predict the checker's reaction to one character and queue it.
    task automatic model_char(input logic [7:0] b, input logic stop_ok);
        exp_t e;
        e = '0;
        e.is_fe = !stop_ok;
        e.data  = b;
        if (!stop_ok) begin
            model_err();
        end else if (!m_locked) begin
            if (b == msg[0]) begin
                m_locked = 1'b1;
                m_ptr    = 1;
            end
        end else if (b == msg[m_ptr]) begin
            m_ptr = m_ptr + 1;
            if (m_ptr == 11) begin
                m_ptr   = 0;
                m_lines = m_lines + 16'd1;
            end
        end else begin
            e.mm = 1'b1;
            model_err();
            m_locked = (b == msg[0]);
            m_ptr    = (b == msg[0]) ? 1 : 0;
        end
        e.lk    = m_locked;
        e.lines = m_lines;
        e.errs  = m_errs;
        exp_q.push_back(e);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge wb_clk_i) begin
        exp_t e;
        if (rst_n && (rx_valid || frame_err)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe actual=valid:%0b,fe:%0b,data:%0h expected=none",
                         rx_valid, frame_err, rx_data);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_kind_fe", {31'd0, frame_err}, {31'd0, e.is_fe});
                chk("strobe_kind_valid", {31'd0, rx_valid}, {31'd0, !e.is_fe});
                if (!e.is_fe) chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                chk("mismatch", {31'd0, mismatch}, {31'd0, e.mm});
                chk("locked", {31'd0, locked}, {31'd0, e.lk});
                chk("line_count", {16'd0, line_count}, {16'd0, e.lines});
                chk("err_count", {24'd0, err_count}, {24'd0, e.errs});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic line_for(input logic v, input int n);
        rx_in = v;
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    // One 8N1 character. Good frames get one extra idle bit; bad frames hold
    // the stop bit low for stop_low bit periods and then idle two periods.
    task automatic send_char(input logic [7:0] b, input logic stop_ok, input int stop_low);
        int p;
        p = int'(baud_div) + 1;
        model_char(b, stop_ok);
        line_for(1'b0, p);
        for (int i = 0; i < 8; i++) line_for(b[i], p);
        if (stop_ok) begin
            line_for(1'b1, 2 * p);
        end else begin
            line_for(1'b0, stop_low * p);
            line_for(1'b1, 2 * p);
        end
    endtask

    task automatic send_msg();
        for (int i = 0; i < 11; i++) send_char(msg[i], 1'b1, 0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge wb_clk_i);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge wb_clk_i);
        #1;
        clear = 1'b0;
        model_reset();
    endtask

    task automatic check_model_state(input string tag);
        chk({tag, "_locked"}, {31'd0, locked}, {31'd0, m_locked});
        chk({tag, "_lines"}, {16'd0, line_count}, {16'd0, m_lines});
        chk({tag, "_errs"}, {24'd0, err_count}, {24'd0, m_errs});
        chk({tag, "_ptr"}, {28'd0, dbg_ptr_o}, m_ptr);
        chk({tag, "_state_idle"}, {29'd0, dbg_state_o}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
        chk({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        chk({tag, "_mismatch"}, {31'd0, mismatch}, 32'd0);
        check_model_state(tag);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int choice;
        int cursor;
        logic [7:0] b;

        // Reset and long idle.
        rst_n = 1'b0;
        repeat (5) @(posedge wb_clk_i);
        #1;
        rst_n = 1'b1;
        model_reset();
        check_reset_outputs("reset");
        line_for(1'b1, 1000);
        check_reset_outputs("idle1000");

        // Whole message twice.
        send_msg();
        send_msg();
        wait_drain();
        check_model_state("two_lines");
        chk("two_lines_count", {16'd0, line_count}, 32'd2);

        // Short glitch then a real 'H'.
        line_for(1'b0, 4);
        line_for(1'b1, 40);
        check_model_state("glitch");
        send_char(8'h48, 1'b1, 0);
        wait_drain();

        // Framing error with the line held low, then a normal character.
        send_char(8'h48, 1'b0, 3);
        send_char(8'h65, 1'b1, 0);
        wait_drain();
        check_model_state("frame_err");

        // Mismatch handling.
        pulse_clear();
        check_model_state("clear1");
        send_char(8'h48, 1'b1, 0);
        send_char(8'h65, 1'b1, 0);
        send_char(8'h6C, 1'b1, 0);
        send_char(8'h58, 1'b1, 0);
        send_msg();
        wait_drain();
        check_model_state("mismatch_x");
        send_char(8'h48, 1'b1, 0);
        send_char(8'h65, 1'b1, 0);
        send_char(8'h6C, 1'b1, 0);
        send_char(8'h48, 1'b1, 0);
        wait_drain();
        check_model_state("mismatch_h");
        chk("relock_ptr_one", {28'd0, dbg_ptr_o}, 32'd1);

        // Randomized traffic at random bit periods.
        for (int r = 0; r < 2; r++) begin
            baud_div = 12'($urandom_range(7, 31));
            line_for(1'b1, 64);
            cursor = 0;
            for (int i = 0; i < 25; i++) begin
                choice = $urandom_range(0, 9);
                if (choice < 5) begin
                    send_char(msg[cursor], 1'b1, 0);
                    cursor = (cursor + 1) % 11;
                end else if (choice < 7) begin
                    send_char(8'h48, 1'b1, 0);
                    cursor = 1;
                end else if (choice < 9) begin
                    b = 8'($urandom_range(0, 255));
                    send_char(b, 1'b1, 0);
                end else begin
                    b = 8'($urandom_range(0, 255));
                    send_char(b, 1'b0, 1);
                end
            end
            wait_drain();
            check_model_state("random");
        end

        // Error counter saturation at the shortest bit period.
        baud_div = 12'd3;
        line_for(1'b1, 16);
        for (int i = 0; i < 300; i++) begin
            b = 8'($urandom_range(0, 255));
            send_char(b, 1'b0, 1);
        end
        wait_drain();
        chk("saturated", {24'd0, err_count}, 32'd255);
        pulse_clear();
        check_model_state("clear2");

        // Reset while a frame is in progress and the line stays low.
        baud_div = 12'd15;
        line_for(1'b1, 32);
        line_for(1'b0, 40);
        rst_n = 1'b0;
        line_for(1'b0, 3);
        rst_n = 1'b1;
        model_reset();
        line_for(1'b0, 60);
        line_for(1'b1, 40);
        check_reset_outputs("reset_mid");
        send_char(8'h48, 1'b1, 0);
        wait_drain();
        check_model_state("after_reset_mid");
        chk("after_reset_mid_data", {24'd0, rx_data}, 32'h48);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hellorld_rx.md
# hellorld_rx

Serial receiver and message checker that sits directly downstream of the "Hellorld!\r\n" UART transmitter on the same single-wire output. It samples the line with an oversampling counter driven by the same 12-bit divisor, deframes 8N1 characters LSB-first, and checks them against the fixed 11-character message. It reports per-byte strobes, lock status, completed-line count and a saturating error count for loopback self-test.

## Interface
- LINE_W, 16: width of line_count (wrapping).
- ERR_W, 8: width of err_count (saturating).
- wb_clk_i  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- rx_in  in  1  serial line, idle high, asynchronous to nothing but may glitch.
- baud_div  in  12  bit period P = baud_div+1 clocks; supported 3..4095.
- clear  in  1  synchronous clear of line_count, err_count, lock.
- rx_data  out  8  last received byte, held until next valid byte.
- rx_valid  out  1  one-cycle strobe, rx_data updated same cycle.
- frame_err  out  1  one-cycle strobe, stop bit sampled 0.
- mismatch  out  1  one-cycle strobe, locked and byte != expected.
- locked  out  1  checker aligned to message.
- line_count  out  LINE_W  complete messages received.
- err_count  out  ERR_W  frame_err + mismatch events, saturates at all-ones.

## Operation
- Input: 2-flop synchronizer (reset 1), plus edge register prev (reset 0).
- RX FSM states IDLE, START, DATA, STOP, WAIT_HIGH; reset to IDLE.
- IDLE: on sync==0 && prev==1 load cnt=0, go START.
- START: cnt increments; at cnt==baud_div>>1 sample: 1 -> IDLE (glitch, no strobe, no error); 0 -> cnt=0, bit=0, DATA.
- DATA: at cnt==baud_div sample into shift reg LSB-first, cnt=0, bit++; after bit 7 go STOP.
- STOP: at cnt==baud_div sample: 1 -> rx_valid, IDLE; 0 -> frame_err, WAIT_HIGH.
- WAIT_HIGH: stay until sync==1, then IDLE.
- Expected sequence, pointer 0..10: 48 65 6C 6C 6F 72 6C 64 21 0D 0A (all 8 bits compared, bit 7 must be 0).
- Unlocked: byte 0x48 -> locked=1, pointer=1; other bytes ignored, no mismatch.
- Locked, byte == expected: pointer++; at pointer 10 (0x0A) -> pointer=0, line_count++ (wraps).
- Locked, byte != expected: mismatch, err_count++, locked=0, pointer=0; if byte is 0x48, relock immediately to pointer 1 (mismatch still pulses).
- frame_err: err_count++; lock and pointer unchanged.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, mismatch=0, locked=0, line_count=0, err_count=0, pointer=0.

## Timing
- t0 = first cycle in IDLE with sync==0, prev==1 (2 clocks after rx_in falls).
- Start sample t0+(baud_div>>1); data bit k sample t0+(baud_div>>1)+(k+1)P; stop sample +9P.
- rx_valid/frame_err registered: asserted cycle after stop sample; mismatch, locked, line_count, err_count update in same cycle as rx_valid.
- Back-to-back frames: IDLE re-arms cycle after stop sample; start edge detected at earliest next cycle. Tolerates transmitter's extra idle bit period between characters.
- clear and increment same cycle: clear wins. clear does not disturb RX FSM or rx_data.
- baud_div change mid-frame: takes effect at next compare; frame content undefined, FSM must still return to IDLE.
- Reset mid-frame: frame dropped, no strobe; prev=0 prevents a still-low line from starting a frame until a real 1->0 edge.
- err_count at all-ones: further errors leave it unchanged.

## Test plan
- Reset, rx_in=1, baud_div=15, 1000 cycles -> no strobes, all outputs at reset values.
- Bench UART model, P=16, 8N1 + one idle bit per char, message sent twice -> 22 rx_valid with bytes 48..0A in order, locked=1 from first 0x48, line_count=2, err_count=0.
- rx_in low 4 cycles then high, baud_div=15 -> no strobes, FSM IDLE, err_count=0; valid 0x48 sent after -> rx_valid, rx_data=0x48.
- 0x48 with stop bit 0, line low 3P then high -> one frame_err, err_count=1, no rx_valid; next 0x65 received normally.
- Locked after "Hel", send 0x58 -> mismatch, err_count+1, locked=0; then full message -> relock, line_count+1; repeat with 0x48 as bad byte -> mismatch and locked stays 1, pointer=1.
- 300 framing errors -> err_count=255; clear pulse -> err_count=0, line_count=0, locked=0.
